// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - 640x480 VGA timing generator with 1-bit framebuffer scanout
`timescale 1ns/1ps
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        rd_en,
  output logic [10:0] rd_x,
  output logic [10:0] rd_y,
  input  logic        rd_data,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_n,
  output logic        VGA_SYNC_n,
  output logic        VGA_CLK,
  output logic        in_vblank,
  output logic        frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic        ce;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        pix_active;
  logic        hs_zone;
  logic        vs_zone;

  // Pixel-phase stage: sync/blank flags captured alongside the read so they
  // line up with the returning rd_data one clk later.
  logic        p_active;
  logic        p_hs_n;
  logic        p_vs_n;

  assign pix_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_zone    = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs_zone    = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

  assign rd_en      = ce && pix_active;
  assign rd_x       = h_cnt;
  assign rd_y       = v_cnt;
  assign in_vblank  = (v_cnt >= V_ACT);
  assign frame_done = ce && (h_cnt == 11'd0) && (v_cnt == V_ACT);
  assign VGA_CLK    = ~ce;
  assign VGA_SYNC_n = 1'b0;

  // Pixel enable: half-rate strobe derived from clk.
  always_ff @(posedge clk) begin
    if (!reset_n) ce <= 1'b0;
    else          ce <= ~ce;
  end

  // Raster counters advance once per pixel; v_cnt steps on the h_cnt wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt <= 11'd0;
      v_cnt <= 11'd0;
    end else if (ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= 11'd0;
        v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  // Capture the flags of the pixel being read, at the end of its ce=1 cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_active <= 1'b0;
      p_hs_n   <= 1'b1;
      p_vs_n   <= 1'b1;
    end else if (ce) begin
      p_active <= pix_active;
      p_hs_n   <= ~hs_zone;
      p_vs_n   <= ~vs_zone;
    end
  end

  // Output pixel register: loads when rd_data is valid and holds for one pixel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_n <= 1'b0;
    end else if (!ce) begin
      VGA_R       <= (p_active && rd_data) ? 8'hFF : 8'h00;
      VGA_G       <= (p_active && rd_data) ? 8'hFF : 8'h00;
      VGA_B       <= (p_active && rd_data) ? 8'hFF : 8'h00;
      VGA_HS      <= p_hs_n;
      VGA_VS      <= p_vs_n;
      VGA_BLANK_n <= p_active;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - directed bench for vga_scanout on a reduced raster
`timescale 1ns/1ps
module tb_vga_scanout;

  // Reduced raster: 25 pixels x 19 lines -> 50 clks/line, 950 clks/frame.
  localparam int TRACE_N = 2100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_en;
  logic [10:0] rd_x;
  logic [10:0] rd_y;
  logic        rd_data;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_n;
  logic        VGA_SYNC_n;
  logic        VGA_CLK;
  logic        in_vblank;
  logic        frame_done;
  logic        force_one;

  int total = 0;
  int bad   = 0;

  logic        t_rden [TRACE_N];
  logic [10:0] t_x    [TRACE_N];
  logic [10:0] t_y    [TRACE_N];
  logic [7:0]  t_r    [TRACE_N];
  logic [7:0]  t_g    [TRACE_N];
  logic [7:0]  t_b    [TRACE_N];
  logic        t_hs   [TRACE_N];
  logic        t_vs   [TRACE_N];
  logic        t_bl   [TRACE_N];
  logic        t_fd   [TRACE_N];
  logic        t_vb   [TRACE_N];
  logic        t_vclk [TRACE_N];

  vga_scanout #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
    .VGA_SYNC_n(VGA_SYNC_n), .VGA_CLK(VGA_CLK),
    .in_vblank(in_vblank), .frame_done(frame_done)
  );

  always #10 clk = ~clk;

  // Framebuffer model: one lit pixel at (5,7), or all lit when force_one.
  always @(posedge clk)
    rd_data <= force_one ? 1'b1 : (rd_en && rd_x == 11'd5 && rd_y == 11'd7);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Index 0 is sampled now; index i is the state after the i-th following edge.
  task automatic rec(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      t_rden[i] = rd_en;  t_x[i] = rd_x;  t_y[i] = rd_y;
      t_r[i] = VGA_R;     t_g[i] = VGA_G; t_b[i] = VGA_B;
      t_hs[i] = VGA_HS;   t_vs[i] = VGA_VS; t_bl[i] = VGA_BLANK_n;
      t_fd[i] = frame_done; t_vb[i] = in_vblank; t_vclk[i] = VGA_CLK;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int fd_first, fd_second, fd_cnt;
    int bl_r1, bl_r2, bl_line0, bl_frame;
    int hs_fall, hs_low, vs_fall, vs_low, vb_cnt;
    int ff_cnt, ff_first, rgb_diff, rd_cnt, bad_col, bad_rd;
    int found;

    reset_n   = 1'b0;
    force_one = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en",  32'(rd_en), 0);
    check("rst_r",      32'(VGA_R), 0);
    check("rst_hs",     32'(VGA_HS), 1);
    check("rst_vs",     32'(VGA_VS), 1);
    check("rst_blank",  32'(VGA_BLANK_n), 0);
    check("rst_fd",     32'(frame_done), 0);
    check("rst_vblank", 32'(in_vblank), 0);
    check("rst_vclk",   32'(VGA_CLK), 1);
    check("rst_sync_n", 32'(VGA_SYNC_n), 0);

    reset_n = 1'b1;
    rec(TRACE_N);

    check("rel_rd_en0", 32'(t_rden[0]), 0);
    check("rel_rd_en1", 32'(t_rden[1]), 1);
    check("rel_x1",     32'(t_x[1]), 0);
    check("rel_y1",     32'(t_y[1]), 0);
    check("rel_blank1", 32'(t_bl[1]), 0);
    check("rel_blank2", 32'(t_bl[2]), 0);
    check("rel_blank3", 32'(t_bl[3]), 1);

    fd_first = -1; fd_second = -1; fd_cnt = 0;
    for (int i = 0; i < TRACE_N; i++)
      if (t_fd[i]) begin
        if (fd_first < 0) fd_first = i;
        else if (fd_second < 0) fd_second = i;
        fd_cnt++;
      end
    check("fd_first",  32'(fd_first), 601);
    check("fd_period", 32'(fd_second - fd_first), 950);
    check("fd_count",  32'(fd_cnt), 2);

    bl_r1 = -1; bl_r2 = -1; bl_line0 = 0; bl_frame = 0;
    hs_fall = -1; hs_low = 0; vs_fall = -1; vs_low = 0; vb_cnt = 0;
    ff_cnt = 0; ff_first = -1; rgb_diff = 0; rd_cnt = 0;
    for (int i = 0; i < 950; i++) begin
      if (i > 0 && t_bl[i] && !t_bl[i-1]) begin
        if (bl_r1 < 0) bl_r1 = i;
        else if (bl_r2 < 0) bl_r2 = i;
      end
      if (i >= 3 && i < 53 && t_bl[i]) bl_line0++;
      if (t_bl[i]) bl_frame++;
      if (i > 0 && !t_hs[i] && t_hs[i-1] && hs_fall < 0) hs_fall = i;
      if (i < 50 && !t_hs[i]) hs_low++;
      if (i > 0 && !t_vs[i] && t_vs[i-1] && vs_fall < 0) vs_fall = i;
      if (!t_vs[i]) vs_low++;
      if (t_vb[i]) vb_cnt++;
      if (t_r[i] == 8'hFF) begin
        ff_cnt++;
        if (ff_first < 0) ff_first = i;
      end
      if (t_g[i] !== t_r[i] || t_b[i] !== t_r[i]) rgb_diff++;
      if (t_rden[i]) rd_cnt++;
    end
    check("blank_rise0",  32'(bl_r1), 3);
    check("line_period",  32'(bl_r2 - bl_r1), 50);
    check("blank_line",   32'(bl_line0), 32);
    check("blank_frame",  32'(bl_frame), 384);
    check("hs_fall",      32'(hs_fall), 39);
    check("hs_low",       32'(hs_low), 8);
    check("vs_fall",      32'(vs_fall), 703);
    check("vs_low",       32'(vs_low), 100);
    check("vblank_cnt",   32'(vb_cnt), 350);
    check("px_rd_en",     32'(t_rden[361]), 1);
    check("px_rd_x",      32'(t_x[361]), 5);
    check("px_rd_y",      32'(t_y[361]), 7);
    check("px_ff_first",  32'(ff_first), 363);
    check("px_ff_count",  32'(ff_cnt), 2);
    check("px_rgb_equal", 32'(rgb_diff), 0);
    check("rd_en_frame",  32'(rd_cnt), 192);
    check("vclk_ce1",     32'(t_vclk[361]), 0);
    check("vclk_ce0",     32'(t_vclk[362]), 1);

    force_one = 1'b1;
    repeat (10) @(negedge clk);
    rec(950);
    bad_col = 0; bad_rd = 0; bl_frame = 0; rd_cnt = 0;
    for (int i = 0; i < 950; i++) begin
      if (t_r[i] !== (t_bl[i] ? 8'hFF : 8'h00)) bad_col++;
      if (t_rden[i] && (t_x[i] > 11'd15 || t_y[i] > 11'd11)) bad_rd++;
      if (t_bl[i]) bl_frame++;
      if (t_rden[i]) rd_cnt++;
    end
    check("force_colour", 32'(bad_col), 0);
    check("force_rd_rng", 32'(bad_rd), 0);
    check("force_blank",  32'(bl_frame), 384);
    check("force_rd_cnt", 32'(rd_cnt), 192);

    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk);
      if (rd_en && rd_x == 11'd10 && rd_y == 11'd5) found = 1;
    end
    check("mid_found", 32'(found), 1);
    check("mid_pre_blank", 32'(VGA_BLANK_n), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rd_en",  32'(rd_en), 0);
    check("mid_blank",  32'(VGA_BLANK_n), 0);
    check("mid_r",      32'(VGA_R), 0);
    check("mid_hs",     32'(VGA_HS), 1);
    check("mid_vs",     32'(VGA_VS), 1);
    check("mid_vclk",   32'(VGA_CLK), 1);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rel_rd_en", 32'(rd_en), 1);
    check("mid_rel_x",     32'(rd_x), 0);
    check("mid_rel_y",     32'(rd_y), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
